// File: rtl/sram_proto_pkg.sv
// sram_proto_pkg: shared command codes, server states, request ops and client FSM states for the onyx SRAM protocol
package sram_proto_pkg;
  localparam logic [3:0] CMD_IDLE  = 4'h0;
  localparam logic [3:0] CMD_CLOSE = 4'h0;
  localparam logic [3:0] CMD_OPEN  = 4'h1;
  localparam logic [3:0] CMD_WRITE = 4'h2;
  localparam logic [3:0] CMD_READ  = 4'h3;
  typedef enum logic [1:0] {
    S_RECEIVE = 2'd0,
    S_ACCEPT  = 2'd1,
    S_SEND    = 2'd2,
    S_READY   = 2'd3
  } server_state_e;
  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_RSV2  = 2'd2,
    OP_RSV3  = 2'd3
  } req_op_e;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SYNC  = 3'd1;
  localparam logic [2:0] ST_OPEN  = 3'd2;
  localparam logic [2:0] ST_ISSUE = 3'd3;
  localparam logic [2:0] ST_CLOSE = 3'd4;
  localparam logic [2:0] ST_RESP  = 3'd5;
  function automatic logic op_valid(input logic [1:0] op);
    return op == OP_WRITE || op == OP_READ;
  endfunction
endpackage

// File: rtl/sram_client_timer.sv
// sram_client_timer: wait-state cycle counter with synchronous clear; expired marks the LIMIT-th enabled cycle
module sram_client_timer #(
  parameter int LIMIT = 64
) (
  input  logic CLK,
  input  logic ASYNCRESETN,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  logic [CW-1:0] cnt;
  always_ff @(posedge CLK or negedge ASYNCRESETN)
    if (!ASYNCRESETN) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign expired = en && cnt == CW'(LIMIT - 1);
endmodule

// File: rtl/sram_client_initiator.sv
// sram_client_initiator: sequences one host write/read onto the onyx SRAM server command bus and returns a response.
// Optional wait-state timeout enabled by defining SRAM_CLIENT_TIMEOUT_EN.
module sram_client_initiator
  import sram_proto_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int CMD_W          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              CLK,
  input  logic              ASYNCRESETN,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [CMD_W-1:0]  offer,
  output logic [DATA_W-1:0] receive,
  input  logic [DATA_W-1:0] send,
  input  logic [1:0]        server_state,
  output logic              busy
);
  logic [2:0] state, nxt;
  logic is_read, adv, tmo, to_hit, tmr_clr, tmr_en;
  assign req_ready = state == ST_IDLE;
  assign busy = !req_ready;
  // adv: the exit condition of the current state holds this cycle
  always_comb begin
    adv = state == ST_IDLE  ? req_valid :
          state == ST_SYNC  ? server_state == S_RECEIVE :
          state == ST_OPEN  ? server_state == S_READY :
          state == ST_ISSUE ? (!is_read || server_state == S_SEND) :
          state == ST_CLOSE ? server_state == S_ACCEPT :
          state == ST_RESP  ? rsp_ready : 1'b0;
    to_hit = tmo && !adv;
    nxt = adv ? (state == ST_IDLE ? (op_valid(req_op) ? ST_SYNC : ST_RESP) :
                 state == ST_RESP ? ST_IDLE : state + 3'd1) :
          to_hit ? ST_RESP : state;
  end
  assign tmr_clr = nxt != state;
  assign tmr_en = state inside {ST_SYNC, ST_OPEN, ST_ISSUE, ST_CLOSE};
`ifdef SRAM_CLIENT_TIMEOUT_EN
  sram_client_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .CLK(CLK),
    .ASYNCRESETN(ASYNCRESETN),
    .clr(tmr_clr),
    .en(tmr_en),
    .expired(tmo)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0) ^ tmr_clr ^ tmr_en;
  assign tmo = 1'b0;
`endif
  always_ff @(posedge CLK or negedge ASYNCRESETN)
    if (!ASYNCRESETN) begin
      state     <= ST_IDLE;
      is_read   <= 1'b0;
      offer     <= CMD_W'(CMD_IDLE);
      receive   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= nxt;
      // CMD_CLOSE and CMD_IDLE share an encoding, so timeout's close-then-idle needs no extra state
      offer     <= nxt == ST_OPEN  ? CMD_W'(CMD_OPEN) :
                   nxt == ST_ISSUE ? CMD_W'(is_read ? CMD_READ : CMD_WRITE) : CMD_W'(CMD_CLOSE);
      rsp_valid <= nxt == ST_RESP;
      rsp_err   <= nxt == ST_RESP && (rsp_err || to_hit || (req_ready && !op_valid(req_op)));
      if (req_ready && req_valid) begin
        is_read <= req_op == OP_READ;
        if (op_valid(req_op)) receive <= req_data;
      end
      if ((req_ready && req_valid) || to_hit) rsp_data <= '0;
      else if (state == ST_ISSUE && is_read && adv) rsp_data <= send;
    end
endmodule

// File: tb/tb_sram_client_initiator.sv
// tb_sram_client_initiator: directed checks of the SRAM client initiator against a cooperative server model.
module tb_sram_client_initiator;
  import sram_proto_pkg::*;
  logic        CLK = 1'b0;
  logic        ASYNCRESETN = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [15:0] req_data = 16'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [3:0]  offer;
  logic [15:0] receive;
  logic [15:0] send;
  logic [1:0]  server_state;
  logic        busy;
  logic        phase;
  logic        hold = 1'b0;
  logic [1:0]  hold_st = 2'd0;
  int checks = 0;
  int errors = 0;

  sram_client_initiator dut (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .offer(offer), .receive(receive), .send(send), .server_state(server_state), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // server model: reacts to offer immediately; phase tells a closing idle apart from a fresh one
  always @(posedge CLK or negedge ASYNCRESETN)
    if (!ASYNCRESETN) phase <= 1'b0;
    else if (offer == CMD_WRITE || offer == CMD_READ) phase <= 1'b1;
    else if (rsp_valid) phase <= 1'b0;
  assign server_state = hold ? hold_st :
                        offer == CMD_OPEN  ? S_READY :
                        offer == CMD_READ  ? S_SEND :
                        offer == CMD_WRITE ? S_READY :
                        phase ? S_ACCEPT : S_RECEIVE;
  assign send = server_state == S_SEND ? 16'hBEEF : 16'h0000;

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic req(input logic [1:0] op, input logic [15:0] data);
    req_valid = 1'b1;
    req_op = op;
    req_data = data;
    tick(1);
    req_valid = 1'b0;
  endtask

  task automatic respond();
    rsp_ready = 1'b1;
    tick(1);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #2 ASYNCRESETN = 1'b0;
    #2;
    chk("rst_offer", 32'(offer), 32'h0);
    chk("rst_receive", 32'(receive), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    tick(2);
    ASYNCRESETN = 1'b1;
    tick(1);

    // 1: write, minimum latency
    req(2'd0, 16'hA5A5);
    chk("w_busy", 32'(busy), 32'h1);
    chk("w_req_ready", 32'(req_ready), 32'h0);
    chk("w_receive", 32'(receive), 32'hA5A5);
    chk("w_sync_offer", 32'(offer), 32'h0);
    tick(1);
    chk("w_offer_open", 32'(offer), 32'h1);
    tick(1);
    chk("w_offer_write", 32'(offer), 32'h2);
    tick(1);
    chk("w_offer_close", 32'(offer), 32'h0);
    chk("w_rsp_early", 32'(rsp_valid), 32'h0);
    tick(1);
    chk("w_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("w_rsp_err", 32'(rsp_err), 32'h0);
    chk("w_rsp_data", 32'(rsp_data), 32'h0);
    respond();
    chk("w_done_valid", 32'(rsp_valid), 32'h0);
    chk("w_done_ready", 32'(req_ready), 32'h1);

    // 2: read captures send word
    req(2'd1, 16'h0003);
    chk("r_receive", 32'(receive), 32'h0003);
    tick(2);
    chk("r_offer_read", 32'(offer), 32'h3);
    tick(1);
    chk("r_offer_close", 32'(offer), 32'h0);
    tick(1);
    chk("r_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("r_rsp_data", 32'(rsp_data), 32'hBEEF);
    chk("r_rsp_err", 32'(rsp_err), 32'h0);
    chk("r_offer_idle", 32'(offer), 32'h0);
    respond();
    chk("r_data_held", 32'(rsp_data), 32'hBEEF);

    // 3: reserved op
    req(2'd2, 16'h1234);
    chk("x_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("x_rsp_err", 32'(rsp_err), 32'h1);
    chk("x_offer", 32'(offer), 32'h0);
    chk("x_receive", 32'(receive), 32'h0003);
    respond();
    chk("x_err_clr", 32'(rsp_err), 32'h0);

    // 4: server stuck in S_ACCEPT while OPEN
    req(2'd0, 16'h00C3);
    tick(1);
    chk("t_offer_open", 32'(offer), 32'h1);
    hold = 1'b1;
    hold_st = S_ACCEPT;
`ifdef SRAM_CLIENT_TIMEOUT_EN
    tick(63);
    chk("t_before_to", 32'(rsp_valid), 32'h0);
    chk("t_still_open", 32'(offer), 32'h1);
    tick(1);
    chk("t_to_valid", 32'(rsp_valid), 32'h1);
    chk("t_to_err", 32'(rsp_err), 32'h1);
    chk("t_to_data", 32'(rsp_data), 32'h0);
    chk("t_to_offer", 32'(offer), 32'h0);
    hold = 1'b0;
    respond();
`else
    tick(80);
    chk("t_still_open", 32'(offer), 32'h1);
    chk("t_no_rsp", 32'(rsp_valid), 32'h0);
    chk("t_busy", 32'(busy), 32'h1);
    hold = 1'b0;
    tick(3);
    chk("t_rel_valid", 32'(rsp_valid), 32'h1);
    chk("t_rel_err", 32'(rsp_err), 32'h0);
    respond();
`endif
    chk("t_idle", 32'(req_ready), 32'h1);

    // 5: response back-pressure with a pending request
    req(2'd0, 16'h0011);
    tick(4);
    chk("b_rsp_valid", 32'(rsp_valid), 32'h1);
    req_valid = 1'b1;
    req_op = 2'd1;
    req_data = 16'h0042;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("b_hold_valid", 32'(rsp_valid), 32'h1);
      chk("b_hold_ready", 32'(req_ready), 32'h0);
      chk("b_hold_data", 32'(rsp_data), 32'h0);
    end
    rsp_ready = 1'b1;
    tick(1);
    rsp_ready = 1'b0;
    chk("b_idle_ready", 32'(req_ready), 32'h1);
    chk("b_idle_valid", 32'(rsp_valid), 32'h0);
    tick(1);
    req_valid = 1'b0;
    chk("b_second_busy", 32'(busy), 32'h1);
    chk("b_second_recv", 32'(receive), 32'h0042);
    tick(4);
    chk("b_second_valid", 32'(rsp_valid), 32'h1);
    chk("b_second_data", 32'(rsp_data), 32'hBEEF);
    respond();

    // 6: reset during ISSUE
    req(2'd1, 16'h0777);
    tick(2);
    chk("a_in_issue", 32'(offer), 32'h3);
    #2 ASYNCRESETN = 1'b0;
    #1;
    chk("a_offer", 32'(offer), 32'h0);
    chk("a_receive", 32'(receive), 32'h0);
    chk("a_busy", 32'(busy), 32'h0);
    chk("a_req_ready", 32'(req_ready), 32'h1);
    chk("a_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("a_rsp_data", 32'(rsp_data), 32'h0);
    tick(1);
    ASYNCRESETN = 1'b1;
    tick(3);
    chk("a_no_rsp", 32'(rsp_valid), 32'h0);
    req(2'd0, 16'h5A5A);
    chk("a_new_recv", 32'(receive), 32'h5A5A);
    tick(4);
    chk("a_new_valid", 32'(rsp_valid), 32'h1);
    chk("a_new_err", 32'(rsp_err), 32'h0);
    respond();
    chk("a_new_done", 32'(req_ready), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
